// File: rtl/simon_pkg.sv
// Shared definitions for the colour-sequence game stages: colour codes,
// capture-stage state encoding and sequence widths.
package simon_pkg;

   localparam int SEQ_W   = 32;
   localparam int ROUND_W = 4;

   localparam logic [1:0] COL_RED    = 2'b00;
   localparam logic [1:0] COL_GREEN  = 2'b01;
   localparam logic [1:0] COL_BLUE   = 2'b10;
   localparam logic [1:0] COL_YELLOW = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RELEASE = 3'd1,
      ST_ARM     = 3'd2,
      ST_DONE    = 3'd3,
      ST_TOUT    = 3'd4
   } wait_state_e;

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

   function automatic logic [1:0] onehot_to_code(input logic [3:0] oh);
      logic [1:0] code;
      case (oh)
         4'b0001: code = COL_RED;
         4'b0010: code = COL_GREEN;
         4'b0100: code = COL_BLUE;
         4'b1000: code = COL_YELLOW;
         default: code = COL_RED;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Stable-level qualifier: level_ok_o pulses on the DEBOUNCE_CYCLES-th
// consecutive cycle in which level_i equals ref_i without changing value.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clear_i,
   input  logic [3:0] level_i,
   input  logic [3:0] ref_i,
   output logic       level_ok_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] run;
   logic [3:0]       prev_q;
   logic             match;
   logic             same;

   always_comb begin
      match      = (level_i == ref_i);
      same       = (cnt_q == '0) || (level_i == prev_q);
      run        = same ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
      level_ok_o = 1'b0;
      cnt_d      = cnt_q;
      if (clear_i || !match) begin
         cnt_d = '0;
      end else if (run == DB_MAX) begin
         // Restart after each qualification so a held level is accepted once.
         level_ok_o = 1'b1;
         cnt_d      = '0;
      end else begin
         cnt_d = run;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         prev_q <= 4'b0000;
      end else begin
         cnt_q  <= cnt_d;
         prev_q <= level_i;
      end
   end

endmodule

// File: rtl/wait_state.sv
// Player-input capture stage: debounces button presses for one round, packs
// them 2 bits per colour (first press in the LSBs) and hands off via en_check.
module wait_state
   import simon_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 1000000
) (
   input  logic               clk,
   input  logic               rst_wait,
   input  logic               en_wait,
   input  logic [ROUND_W-1:0] round_ctr_in,
   input  logic [3:0]         btn,
   output logic [SEQ_W-1:0]   seq_in_check,
   output logic               en_check,
   output logic               timeout,
   output logic               busy,
   output logic [4:0]         press_idx
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

   wait_state_e      state_q, state_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [4:0]       idx_q, idx_d;
   logic [4:0]       target_q, target_d;
   logic [TO_W-1:0]  tcnt_q, tcnt_d;
   logic [TO_W-1:0]  tcnt_inc;
   logic             en_check_q, en_check_d;
   logic             timeout_q, timeout_d;
   logic             busy_q;
   logic             tout_hit;

   logic       db_clear;
   logic [3:0] db_ref;
   logic       db_ok;

   // RELEASE qualifies all-zero; ARM qualifies a one-hot level against itself,
   // while any other level is compared with its complement and never matches.
   assign db_clear = (state_q != ST_RELEASE) && (state_q != ST_ARM);
   assign db_ref   = (state_q == ST_RELEASE) ? 4'b0000 :
                     (is_onehot(btn) ? btn : ~btn);

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk_i     (clk),
      .rst_i     (rst_wait),
      .clear_i   (db_clear),
      .level_i   (btn),
      .ref_i     (db_ref),
      .level_ok_o(db_ok)
   );

   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q;
      idx_d      = idx_q;
      target_d   = target_q;
      tcnt_d     = tcnt_q;
      timeout_d  = timeout_q;
      en_check_d = 1'b0;
      tcnt_inc   = (tcnt_q == TO_MAX) ? tcnt_q : (tcnt_q + TO_W'(1));
      tout_hit   = (tcnt_inc == TO_MAX);

      case (state_q)
         ST_IDLE: begin
            if (en_wait) begin
               target_d  = {1'b0, round_ctr_in} + 5'd1;
               seq_d     = '0;
               idx_d     = 5'd0;
               timeout_d = 1'b0;
               tcnt_d    = '0;
               state_d   = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            tcnt_d = tcnt_inc;
            if (tout_hit) begin
               timeout_d = 1'b1;
               state_d   = ST_TOUT;
            end else if (db_ok) begin
               state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            tcnt_d = tcnt_inc;
            if (tout_hit) begin
               timeout_d = 1'b1;
               state_d   = ST_TOUT;
            end else if (db_ok) begin
               seq_d[{idx_q[3:0], 1'b0} +: 2] = onehot_to_code(btn);
               idx_d  = idx_q + 5'd1;
               tcnt_d = '0;
               if (idx_d == target_q) begin
                  en_check_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  state_d = ST_RELEASE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_TOUT: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_wait) begin
      if (rst_wait) begin
         state_q    <= ST_IDLE;
         seq_q      <= '0;
         idx_q      <= 5'd0;
         target_q   <= 5'd0;
         tcnt_q     <= '0;
         en_check_q <= 1'b0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         idx_q      <= idx_d;
         target_q   <= target_d;
         tcnt_q     <= tcnt_d;
         en_check_q <= en_check_d;
         timeout_q  <= timeout_d;
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   assign seq_in_check = seq_q;
   assign en_check     = en_check_q;
   assign timeout      = timeout_q;
   assign busy         = busy_q;
   assign press_idx    = idx_q;

endmodule

// File: tb/tb_wait_state.sv
// Directed bench for the capture stage with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100.
module tb_wait_state;

   logic        clk = 1'b0;
   logic        rst_wait;
   logic        en_wait;
   logic [3:0]  round_ctr_in;
   logic [3:0]  btn;
   logic [31:0] seq_in_check;
   logic        en_check;
   logic        timeout;
   logic        busy;
   logic [4:0]  press_idx;

   int checks   = 0;
   int failures = 0;
   int pulses   = 0;
   int p0;

   always #5 clk = ~clk;

   wait_state #(
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk         (clk),
      .rst_wait    (rst_wait),
      .en_wait     (en_wait),
      .round_ctr_in(round_ctr_in),
      .btn         (btn),
      .seq_in_check(seq_in_check),
      .en_check    (en_check),
      .timeout     (timeout),
      .busy        (busy),
      .press_idx   (press_idx)
   );

   always @(negedge clk) if (en_check === 1'b1) pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_round(input logic [3:0] r);
      en_wait      = 1'b1;
      round_ctr_in = r;
      cycles(1);
      en_wait = 1'b0;
      btn     = 4'b0000;
   endtask

   task automatic press(input logic [3:0] v);
      btn = v;
      cycles(6);
      btn = 4'b0000;
      cycles(6);
   endtask

   initial begin
      rst_wait     = 1'b1;
      en_wait      = 1'b0;
      round_ctr_in = 4'd0;
      btn          = 4'b0000;
      cycles(2);
      check("rst_seq", seq_in_check, 32'h0);
      check("rst_idx", {27'd0, press_idx}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_en_check", {31'd0, en_check}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      rst_wait = 1'b0;
      cycles(1);

      // Round 0, single blue press: accepted on the 4th held cycle.
      p0 = pulses;
      start_round(4'd0);
      check("r0_busy_armed", {31'd0, busy}, 32'd1);
      cycles(6);
      btn = 4'b0100;
      cycles(3);
      check("r0_no_early_accept", {27'd0, press_idx}, 32'd0);
      check("r0_no_early_en", {31'd0, en_check}, 32'd0);
      cycles(1);
      check("r0_en_check", {31'd0, en_check}, 32'd1);
      check("r0_busy_in_done", {31'd0, busy}, 32'd1);
      check("r0_seq", seq_in_check, 32'h00000002);
      check("r0_idx", {27'd0, press_idx}, 32'd1);
      cycles(1);
      check("r0_busy_falls", {31'd0, busy}, 32'd0);
      check("r0_en_drops", {31'd0, en_check}, 32'd0);
      cycles(4);
      btn = 4'b0000;
      cycles(2);
      check("r0_pulses", pulses - p0, 32'd1);
      check("r0_seq_hold", seq_in_check, 32'h00000002);

      // Round 3: red, green, blue, yellow.
      p0 = pulses;
      start_round(4'd3);
      cycles(6);
      press(4'b0001);
      press(4'b0010);
      press(4'b0100);
      press(4'b1000);
      check("r3_seq", seq_in_check, 32'h000000E4);
      check("r3_idx", {27'd0, press_idx}, 32'd4);
      check("r3_pulses", pulses - p0, 32'd1);
      check("r3_busy", {31'd0, busy}, 32'd0);
      check("r3_timeout", {31'd0, timeout}, 32'd0);

      // Glitches: short green pulse and a two-button press are rejected.
      p0 = pulses;
      start_round(4'd0);
      cycles(6);
      btn = 4'b0010;
      cycles(3);
      btn = 4'b0011;
      cycles(20);
      check("glitch_idx", {27'd0, press_idx}, 32'd0);
      check("glitch_seq", seq_in_check, 32'h0);
      check("glitch_busy", {31'd0, busy}, 32'd1);
      check("glitch_pulses", pulses - p0, 32'd0);
      btn = 4'b0000;
      cycles(2);
      btn = 4'b1000;
      cycles(6);
      btn = 4'b0000;
      cycles(2);
      check("glitch_yellow_seq", seq_in_check, 32'h00000003);
      check("glitch_yellow_idx", {27'd0, press_idx}, 32'd1);
      check("glitch_yellow_pulses", pulses - p0, 32'd1);

      // Timeout: no press for 100 cycles after arming.
      p0 = pulses;
      start_round(4'd2);
      cycles(99);
      check("to_not_yet", {31'd0, timeout}, 32'd0);
      check("to_busy_waiting", {31'd0, busy}, 32'd1);
      cycles(1);
      check("to_set", {31'd0, timeout}, 32'd1);
      check("to_busy_in_tout", {31'd0, busy}, 32'd1);
      cycles(1);
      check("to_busy_idle", {31'd0, busy}, 32'd0);
      check("to_held", {31'd0, timeout}, 32'd1);
      check("to_idx", {27'd0, press_idx}, 32'd0);
      check("to_pulses", pulses - p0, 32'd0);
      cycles(3);
      check("to_still_held", {31'd0, timeout}, 32'd1);
      start_round(4'd0);
      check("to_cleared", {31'd0, timeout}, 32'd0);
      check("to_restart_busy", {31'd0, busy}, 32'd1);
      cycles(6);
      press(4'b0001);
      check("to_restart_idx", {27'd0, press_idx}, 32'd1);
      check("to_restart_seq", seq_in_check, 32'h0);

      // Round 15: sixteen yellow presses fill the word.
      p0 = pulses;
      start_round(4'd15);
      cycles(6);
      for (int i = 0; i < 16; i++) press(4'b1000);
      check("r15_seq", seq_in_check, 32'hFFFFFFFF);
      check("r15_idx", {27'd0, press_idx}, 32'd16);
      check("r15_pulses", pulses - p0, 32'd1);
      check("r15_busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset after two of four presses.
      p0 = pulses;
      start_round(4'd3);
      cycles(6);
      press(4'b0001);
      press(4'b0100);
      check("mid_idx", {27'd0, press_idx}, 32'd2);
      check("mid_seq", seq_in_check, 32'h00000008);
      check("mid_busy", {31'd0, busy}, 32'd1);
      #2;
      rst_wait = 1'b1;
      #1;
      check("async_seq", seq_in_check, 32'h0);
      check("async_idx", {27'd0, press_idx}, 32'd0);
      check("async_busy", {31'd0, busy}, 32'd0);
      check("async_en_check", {31'd0, en_check}, 32'd0);
      check("async_timeout", {31'd0, timeout}, 32'd0);
      cycles(1);
      rst_wait = 1'b0;
      cycles(1);
      start_round(4'd0);
      cycles(6);
      press(4'b0010);
      check("post_rst_seq", seq_in_check, 32'h00000001);
      check("post_rst_idx", {27'd0, press_idx}, 32'd1);
      check("post_rst_pulses", pulses - p0, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
